// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard/flush sequencer.
package pipeline_ctrl_pkg;

  // Operand select encodings for the EX-stage operand muxes.
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef enum logic [1:0] {
    CTRL_RUN   = 2'd0,
    CTRL_DRAIN = 2'd1,
    CTRL_HALT  = 2'd2
  } ctrl_state_e;

  // One in-flight register writer.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } sb_entry_t;

  // x0 never matches: it is hardwired zero and cannot carry a dependency.
  function automatic logic src_match(input logic used, input logic [4:0] rs,
                                     input sb_entry_t e);
    return used && (rs != 5'd0) && e.valid && (e.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Two-entry writer scoreboard tracking the instructions in EX and MEM.
// The regfile is write-through, so WB-stage writers are not tracked.
module hazard_scoreboard
  import pipeline_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rd_addr,
  input  logic       id_wb_en,
  input  logic       id_is_load,
  input  logic       bubble,
  input  logic [4:0] rs1_addr,
  input  logic       rs1_used,
  input  logic [4:0] rs2_addr,
  input  logic       rs2_used,
  output logic       ex_match_a,
  output logic       ex_match_b,
  output logic       mem_match_a,
  output logic       mem_match_b,
  output logic       ex_is_load
);

  sb_entry_t ex_q, ex_d, mem_q;

  // Entry for the instruction about to enter EX; a bubble carries no writer.
  always_comb begin
    ex_d = '0;
    if (!bubble) begin
      ex_d.valid   = id_valid && id_wb_en && (id_rd_addr != 5'd0);
      ex_d.rd      = id_rd_addr;
      ex_d.is_load = id_is_load;
    end
  end

  // Shift every cycle, including stalls (a stall inserts a bubble into EX).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else begin
      mem_q <= ex_q;
      ex_q  <= ex_d;
    end
  end

  // Per-source match against each tracked stage.
  always_comb begin
    ex_match_a  = src_match(rs1_used, rs1_addr, ex_q);
    ex_match_b  = src_match(rs2_used, rs2_addr, ex_q);
    mem_match_a = src_match(rs1_used, rs1_addr, mem_q);
    mem_match_b = src_match(rs2_used, rs2_addr, mem_q);
    ex_is_load  = ex_q.is_load;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/flush sequencer for a 5-stage RV32I pipeline.
// Build option FWD_EN: when defined, forwarding selects are live and only
// load-use stalls occur; otherwise selects stay 00 and any EX/MEM RAW stalls.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYC = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [4:0] id_rd_addr,
  input  logic       id_wb_en,
  input  logic       id_is_load,
  input  logic       id_ecall,
  input  logic       ex_br_taken,
  output logic       fe_stall,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic [1:0] ex_fwd_a,
  output logic [1:0] ex_fwd_b,
  output logic       halt
);

`ifdef FWD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  localparam int unsigned CntW = $clog2(DRAIN_CYC + 1);

  ctrl_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]    fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic          ex_match_a, ex_match_b, mem_match_a, mem_match_b, ex_is_load;
  logic          hazard;

  hazard_scoreboard u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rd_addr  (id_rd_addr),
    .id_wb_en    (id_wb_en),
    .id_is_load  (id_is_load),
    .bubble      (idex_bubble),
    .rs1_addr    (id_rs1_addr),
    .rs1_used    (id_rs1_used),
    .rs2_addr    (id_rs2_addr),
    .rs2_used    (id_rs2_used),
    .ex_match_a  (ex_match_a),
    .ex_match_b  (ex_match_b),
    .mem_match_a (mem_match_a),
    .mem_match_b (mem_match_b),
    .ex_is_load  (ex_is_load)
  );

  // With forwarding only a load in EX cannot be bypassed in time.
  always_comb begin
    if (FwdEn) hazard = ex_is_load && (ex_match_a || ex_match_b);
    else       hazard = ex_match_a || ex_match_b || mem_match_a || mem_match_b;
  end

  // Sequencer next state and pipeline control outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fe_stall    = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    unique case (state_q)
      CTRL_RUN: begin
        if (ex_br_taken) begin
          // Redirect wins over any stall, including a younger ECALL.
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (id_valid && hazard) begin
          fe_stall    = 1'b1;
          idex_bubble = 1'b1;
        end else if (id_valid && id_ecall) begin
          state_d = CTRL_DRAIN;
          cnt_d   = CntW'(DRAIN_CYC);
        end
      end
      CTRL_DRAIN: begin
        // ECALL is the oldest in flight, so branch outcomes are ignored here.
        fe_stall   = 1'b1;
        ifid_flush = 1'b1;
        cnt_d      = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = CTRL_HALT;
      end
      CTRL_HALT: begin
        fe_stall    = 1'b1;
        idex_bubble = 1'b1;
      end
      default: state_d = CTRL_RUN;
    endcase
  end

  // Forward selects for the instruction advancing into EX; EX writer has priority.
  always_comb begin
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (FwdEn && id_valid && !idex_bubble) begin
      if (ex_match_a)       fwd_a_d = FWD_EXMEM;
      else if (mem_match_a) fwd_a_d = FWD_MEMWB;
      if (ex_match_b)       fwd_b_d = FWD_EXMEM;
      else if (mem_match_b) fwd_b_d = FWD_MEMWB;
    end
  end

  // State, drain counter and registered forward selects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CTRL_RUN;
      cnt_q   <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign ex_fwd_a = fwd_a_q;
  assign ex_fwd_b = fwd_b_q;
  assign halt     = (state_q == CTRL_HALT);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: the driver queues hand-computed expected
// outputs per cycle, a monitor on the falling edge pops and compares them.
module tb_pipeline_ctrl;

  typedef struct packed {
    logic       stall;
    logic       flush;
    logic       bubble;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       halt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1_addr = '0;
  logic [4:0] id_rs2_addr = '0;
  logic       id_rs1_used = 1'b0;
  logic       id_rs2_used = 1'b0;
  logic [4:0] id_rd_addr = '0;
  logic       id_wb_en = 1'b0;
  logic       id_is_load = 1'b0;
  logic       id_ecall = 1'b0;
  logic       ex_br_taken = 1'b0;
  logic       fe_stall, ifid_flush, idex_bubble, halt;
  logic [1:0] ex_fwd_a, ex_fwd_b;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  pipeline_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rd_addr  (id_rd_addr),
    .id_wb_en    (id_wb_en),
    .id_is_load  (id_is_load),
    .id_ecall    (id_ecall),
    .ex_br_taken (ex_br_taken),
    .fe_stall    (fe_stall),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .ex_fwd_a    (ex_fwd_a),
    .ex_fwd_b    (ex_fwd_b),
    .halt        (halt)
  );

  always #5 clk = ~clk;

  function automatic exp_t ex(input logic s, input logic f, input logic b,
                              input logic [1:0] fa, input logic [1:0] fb, input logic h);
    exp_t e;
    e.stall = s; e.flush = f; e.bubble = b; e.fa = fa; e.fb = fb; e.halt = h;
    return e;
  endfunction

  localparam exp_t E0    = '0;
  localparam exp_t EStl  = exp_t'({1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0});
  localparam exp_t EFlu  = exp_t'({1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0});
  localparam exp_t EDrn  = exp_t'({1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0});
  localparam exp_t EHlt  = exp_t'({1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1});

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] req,
                       input int cyc);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @item %0d: got %b expected %b", name, cyc, act, req);
    end
  endtask

  // Monitor: compare every cycle's outputs against the queued expectation.
  int item = 0;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("fe_stall",    {1'b0, fe_stall},    {1'b0, e.stall},  item);
      check("ifid_flush",  {1'b0, ifid_flush},  {1'b0, e.flush},  item);
      check("idex_bubble", {1'b0, idex_bubble}, {1'b0, e.bubble}, item);
      check("ex_fwd_a",    ex_fwd_a,            e.fa,             item);
      check("ex_fwd_b",    ex_fwd_b,            e.fb,             item);
      check("halt",        {1'b0, halt},        {1'b0, e.halt},   item);
      item++;
    end
  end

  // Drive one cycle of ID/EX inputs just after the rising edge and queue the expectation.
  task automatic cyc(input logic rst, input logic v, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                     input logic wb, input logic ld, input logic ec, input logic br,
                     input exp_t e);
    @(posedge clk);
    #1;
    rst_n       = rst;
    id_valid    = v;
    id_rs1_addr = rs1;
    id_rs1_used = u1;
    id_rs2_addr = rs2;
    id_rs2_used = u2;
    id_rd_addr  = rd;
    id_wb_en    = wb;
    id_is_load  = ld;
    id_ecall    = ec;
    ex_br_taken = br;
    exp_q.push_back(e);
  endtask

  task automatic nop(input exp_t e);
    cyc(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, e);
  endtask

  initial begin
    // Reset state
    cyc(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E0);
    cyc(1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, E0);
    nop(E0);

    // addi x0,x1 ; add x7,x0,x0 : x0 never matches
    cyc(1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, E0);
    cyc(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, E0);
    nop(E0); nop(E0); nop(E0);

`ifndef FWD_EN
    // addi x5 ; add x6,x5,x1 : two stall cycles
    cyc(1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, E0);
    cyc(1'b1, 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, EStl);
    cyc(1'b1, 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, EStl);
    cyc(1'b1, 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, E0);
    nop(E0); nop(E0); nop(E0);
    // addi x5 ; nop ; add x6,x5,x5 : one stall on the MEM writer
    cyc(1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, E0);
    nop(E0);
    cyc(1'b1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, EStl);
    cyc(1'b1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, E0);
    nop(E0); nop(E0); nop(E0);
    // addi x5 ; sw x5,0(x2) : rs2-only dependency
    cyc(1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, E0);
    cyc(1'b1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, EStl);
    cyc(1'b1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, EStl);
    cyc(1'b1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E0);
    nop(E0); nop(E0);
`else
    // lw x5 ; add x6,x5,x1 : one load-use stall, then x5 comes from MEM/WB
    cyc(1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, E0);
    cyc(1'b1, 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, EStl);
    cyc(1'b1, 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, E0);
    nop(ex(1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0));
    nop(E0); nop(E0);
    // addi x5 ; add x6,x5,x5 : no stall, both from EX/MEM
    cyc(1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, E0);
    cyc(1'b1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, E0);
    nop(ex(1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0));
    nop(E0); nop(E0);
    // addi x5 ; nop ; add x6,x5,x5 : no stall, both from MEM/WB
    cyc(1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, E0);
    nop(E0);
    cyc(1'b1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, E0);
    nop(ex(1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0));
    nop(E0); nop(E0);
    // addi x5 ; addi x5 ; add x6,x5,x2 : EX writer beats MEM writer
    cyc(1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, E0);
    cyc(1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, E0);
    cyc(1'b1, 1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, E0);
    nop(ex(1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0));
    nop(E0); nop(E0);
`endif

    // lw x5 ; add x6,x5,x1 with taken branch in EX : redirect wins
    cyc(1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, E0);
    cyc(1'b1, 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, EFlu);
    nop(E0); nop(E0); nop(E0);

    // ECALL in ID with taken branch : ECALL flushed, stays in RUN
    cyc(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, EFlu);
    nop(E0);
    nop(E0);

    // ECALL advances : three drain cycles (branches ignored), then halt
    cyc(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E0);
    cyc(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, EDrn);
    nop(EDrn);
    cyc(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, EDrn);
    nop(EHlt);
    cyc(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, EHlt);
    nop(EHlt);

    // Reset pulse mid-cycle clears halt; normal hazard detection resumes
    cyc(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E0);
    nop(E0);
    cyc(1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, E0);
    cyc(1'b1, 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, EStl);
    nop(E0);

    // Let the monitor drain the queue, with a bound.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL queue_drain: %0d expectations left, expected 0", exp_q.size());
    end
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
